text_console: RTL and testbench

Character-cell text buffer that sits directly downstream of the ASCII 5x7 font generator. A host streams bytes in through a valid/ready port, and the block stores them in a COLS x ROWS character RAM with cursor, control-code and wrap handling. On the display side it reads the cell addressed by the generator's char_x/char_y and indexes the generator's 256-bit ascii_char vector to produce a 1-bit video pixel.

---
 rtl/text_console.sv | 175 +++++++++++++++++
 tb/tb_text_console.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-cell text buffer: host byte stream into a COLS x ROWS character RAM,
// read back by the font generator's char_x/char_y to select one glyph pixel.
module text_console #(
   parameter int COLS = 100,
   parameter int ROWS = 60,
   parameter int X0   = 0,
   parameter int Y0   = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         blank,
   input  logic [7:0]   char_x,
   input  logic [7:0]   char_y,
   input  logic [255:0] ascii_char,
   input  logic         wr_valid,
   input  logic [7:0]   wr_data,
   output logic         wr_ready,
   output logic [7:0]   cur_col,
   output logic [7:0]   cur_row,
   output logic         pix_out,
   output logic         blank_out
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_ROW} state_t;

   state_t      state_reg;
   logic [15:0] clr_addr_reg;
   logic [7:0]  clr_cnt_reg;
   logic [7:0]  col_reg;
   logic [7:0]  row_reg;
   logic        ready_reg;

   logic [7:0]  mem [0:CELLS-1];
   logic [7:0]  ram_q;

   logic        accept;
   logic        printable;
   logic        last_col;
   logic        adv_row;
   logic [7:0]  next_row;
   logic [15:0] cur_addr;
   logic [15:0] row_base;

   logic        mem_we;
   logic [15:0] mem_waddr;
   logic [7:0]  mem_wdata;

   assign accept    = wr_valid & ready_reg;
   assign printable = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
   assign last_col  = (col_reg == 8'(COLS - 1));
   assign next_row  = (row_reg == 8'(ROWS - 1)) ? 8'd0 : row_reg + 8'd1;
   assign cur_addr  = 16'(row_reg) * 16'(COLS) + 16'(col_reg);
   assign row_base  = 16'(next_row) * 16'(COLS);
   assign adv_row   = accept && ((printable && last_col) || (wr_data == 8'h0A));

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_addr_reg;
      mem_wdata = 8'h20;
      if (!reset) begin
         case (state_reg)
            CLEAR_ALL, CLEAR_ROW: mem_we = 1'b1;
            default: begin
               if (accept && printable) begin
                  mem_we    = 1'b1;
                  mem_waddr = cur_addr;
                  mem_wdata = wr_data;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr[AW-1:0]] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= CLEAR_ALL;
         clr_addr_reg <= 16'd0;
         clr_cnt_reg  <= 8'd0;
         col_reg      <= 8'd0;
         row_reg      <= 8'd0;
         ready_reg    <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR_ALL: begin
               clr_addr_reg <= clr_addr_reg + 16'd1;
               if (clr_addr_reg == 16'(CELLS - 1)) begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            end
            CLEAR_ROW: begin
               clr_addr_reg <= clr_addr_reg + 16'd1;
               clr_cnt_reg  <= clr_cnt_reg + 8'd1;
               if (clr_cnt_reg == 8'(COLS - 1)) begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               if (adv_row) begin
                  // Entering a fresh row: blank it before taking more bytes.
                  col_reg      <= 8'd0;
                  row_reg      <= next_row;
                  state_reg    <= CLEAR_ROW;
                  clr_addr_reg <= row_base;
                  clr_cnt_reg  <= 8'd0;
                  ready_reg    <= 1'b0;
               end else if (accept) begin
                  if (printable) begin
                     col_reg <= col_reg + 8'd1;
                  end else begin
                     case (wr_data)
                        8'h0D: col_reg <= 8'd0;
                        8'h08: if (col_reg != 8'd0) col_reg <= col_reg - 8'd1;
                        8'h0C: begin
                           col_reg      <= 8'd0;
                           row_reg      <= 8'd0;
                           state_reg    <= CLEAR_ALL;
                           clr_addr_reg <= 16'd0;
                           ready_reg    <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign wr_ready = ready_reg;
   assign cur_col  = col_reg;
   assign cur_row  = row_reg;

   logic        window;
   logic        window_d1;
   logic        blank_d1;
   logic [7:0]  rel_x;
   logic [7:0]  rel_y;
   logic [15:0] rd_addr;

   assign window = (int'(char_x) >= X0) && (int'(char_x) < X0 + COLS) &&
                   (int'(char_y) >= Y0) && (int'(char_y) < Y0 + ROWS);
   assign rel_x   = char_x - 8'(X0);
   assign rel_y   = char_y - 8'(Y0);
   // Out-of-window positions read cell 0; the pixel is masked anyway.
   assign rd_addr = window ? (16'(rel_y) * 16'(COLS) + 16'(rel_x)) : 16'd0;

   always_ff @(posedge clk) begin
      ram_q <= mem[rd_addr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         window_d1 <= 1'b0;
         blank_d1  <= 1'b1;
         blank_out <= 1'b1;
         pix_out   <= 1'b0;
      end else begin
         window_d1 <= window;
         blank_d1  <= blank;
         blank_out <= blank_d1;
         pix_out   <= ascii_char[ram_q] & window_d1 & ~blank_d1;
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console: clears, printing, wrap,
// row scroll, backspace, window edges and reset during a clear.
module tb_text_console;

   localparam int COLS = 100;
   localparam int ROWS = 60;

   logic         clk = 1'b0;
   logic         reset;
   logic         blank;
   logic [7:0]   char_x;
   logic [7:0]   char_y;
   logic [255:0] ascii_char;
   logic         wr_valid;
   logic [7:0]   wr_data;
   logic         wr_ready;
   logic [7:0]   cur_col;
   logic [7:0]   cur_row;
   logic         pix_out;
   logic         blank_out;

   int checks = 0;
   int failures = 0;

   text_console #(.COLS(COLS), .ROWS(ROWS), .X0(0), .Y0(0)) dut (
      .clk(clk), .reset(reset), .blank(blank), .char_x(char_x), .char_y(char_y),
      .ascii_char(ascii_char), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .cur_col(cur_col), .cur_row(cur_row),
      .pix_out(pix_out), .blank_out(blank_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] oh(input logic [7:0] c);
      logic [255:0] g;
      g = '0;
      g[c] = 1'b1;
      return g;
   endfunction

   task automatic wait_ready(output int n);
      n = 0;
      while (!wr_ready && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      wait_ready(n);
      check("send_ready", {31'd0, wr_ready}, 32'd1);
      wr_valid = 1'b1;
      wr_data  = b;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      $display("tx byte=0x%02h col=%0d row=%0d ready=%0b", b, cur_col, cur_row, wr_ready);
   endtask

   task automatic probe(input int x, input int y, input logic [255:0] g, output logic p);
      char_x = 8'(x);
      char_y = 8'(y);
      ascii_char = g;
      @(posedge clk); @(posedge clk); #1;
      p = pix_out;
   endtask

   // One cell per clock; pix_out for cell k appears one loop iteration later.
   task automatic scan(input int ylo, input int yhi, input logic [255:0] g,
                       input logic b, output int ones);
      int n;
      n = (yhi - ylo + 1) * COLS;
      ones = 0;
      ascii_char = g;
      blank = b;
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            char_x = 8'(k % COLS);
            char_y = 8'(ylo + k / COLS);
         end
         @(posedge clk); #1;
         if (k >= 1 && pix_out === 1'b1) ones++;
      end
      blank = 1'b0;
   endtask

   initial begin
      int n;
      int ones;
      logic p;

      reset = 1'b1; blank = 1'b1; char_x = '0; char_y = '0; ascii_char = '0;
      wr_valid = 1'b0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_col", {24'd0, cur_col}, 32'd0);
      check("rst_row", {24'd0, cur_row}, 32'd0);
      check("rst_pix", {31'd0, pix_out}, 32'd0);
      check("rst_blank_out", {31'd0, blank_out}, 32'd1);

      reset = 1'b0;
      wait_ready(n);
      check("clear_all_len", n, 32'd6000);

      scan(0, ROWS - 1, oh(8'h20), 1'b0, ones);
      check("all_space", ones, 32'd6000);
      scan(0, ROWS - 1, '1, 1'b1, ones);
      check("blank_frame_zero", ones, 32'd0);

      blank = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      blank = 1'b0;
      @(posedge clk); #1;
      check("blank_out_d1", {31'd0, blank_out}, 32'd1);
      @(posedge clk); #1;
      check("blank_out_d2", {31'd0, blank_out}, 32'd0);

      probe(99, 0, '1, p);  check("win_x_last", {31'd0, p}, 32'd1);
      probe(100, 0, '1, p); check("win_x_out", {31'd0, p}, 32'd0);
      probe(0, 59, '1, p);  check("win_y_last", {31'd0, p}, 32'd1);
      probe(0, 60, '1, p);  check("win_y_out", {31'd0, p}, 32'd0);

      send(8'h41);
      send(8'h42);
      check("ab_col", {24'd0, cur_col}, 32'd2);
      check("ab_row", {24'd0, cur_row}, 32'd0);
      check("ab_ready", {31'd0, wr_ready}, 32'd1);
      probe(0, 0, oh(8'h41), p);  check("cell0_A", {31'd0, p}, 32'd1);
      probe(0, 0, ~oh(8'h41), p); check("cell0_notA", {31'd0, p}, 32'd0);
      probe(1, 0, oh(8'h42), p);  check("cell1_B", {31'd0, p}, 32'd1);

      send(8'h0D);
      check("cr_col", {24'd0, cur_col}, 32'd0);

      for (int i = 0; i < 99; i++) send(8'h78);
      check("x99_col", {24'd0, cur_col}, 32'd99);
      send(8'h78);
      check("wrap_col", {24'd0, cur_col}, 32'd0);
      check("wrap_row", {24'd0, cur_row}, 32'd1);
      check("wrap_ready_low", {31'd0, wr_ready}, 32'd0);
      wait_ready(n);
      check("clear_row_len", n, 32'd100);
      scan(0, 0, oh(8'h78), 1'b0, ones);
      check("row0_x", ones, 32'd100);
      scan(1, 1, oh(8'h20), 1'b0, ones);
      check("row1_space", ones, 32'd100);

      send(8'h51);
      for (int i = 0; i < 58; i++) send(8'h0A);
      check("lf_row59", {24'd0, cur_row}, 32'd59);
      send(8'h45);
      send(8'h0A);
      check("lf_wrap_row", {24'd0, cur_row}, 32'd0);
      check("lf_wrap_col", {24'd0, cur_col}, 32'd0);
      wait_ready(n);
      scan(0, 0, oh(8'h20), 1'b0, ones);
      check("row0_cleared", ones, 32'd100);
      probe(0, 1, oh(8'h51), p);  check("row1_kept", {31'd0, p}, 32'd1);
      probe(0, 59, oh(8'h45), p); check("row59_E", {31'd0, p}, 32'd1);

      send(8'h08);
      check("bs_col0", {24'd0, cur_col}, 32'd0);
      check("bs_row0", {24'd0, cur_row}, 32'd0);
      send(8'h5A);
      send(8'h08);
      check("bs_col", {24'd0, cur_col}, 32'd0);
      send(8'h59);
      check("zy_col", {24'd0, cur_col}, 32'd1);
      probe(0, 0, oh(8'h59), p); check("cell0_Y", {31'd0, p}, 32'd1);
      send(8'h07);
      send(8'h7F);
      check("ignored_col", {24'd0, cur_col}, 32'd1);
      probe(1, 0, oh(8'h20), p); check("ignored_nowrite", {31'd0, p}, 32'd1);

      send(8'h0C);
      check("ff_ready", {31'd0, wr_ready}, 32'd0);
      check("ff_col", {24'd0, cur_col}, 32'd0);
      repeat (3000) @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data  = 8'h41;
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("mid_rst_ready", {31'd0, wr_ready}, 32'd0);
      reset = 1'b0;
      wait_ready(n);
      wr_valid = 1'b0;
      check("mid_rst_clear_len", n, 32'd6000);
      check("mid_rst_col", {24'd0, cur_col}, 32'd0);
      check("mid_rst_row", {24'd0, cur_row}, 32'd0);
      probe(0, 0, oh(8'h20), p);  check("mid_rst_cell0", {31'd0, p}, 32'd1);
      probe(0, 59, oh(8'h20), p); check("mid_rst_cell59", {31'd0, p}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
